softmax_exp_scheduler: RTL

- Row-level controller that sequences the shared fixed-latency exponent unit (S9Q10 in, U0Q25 out, 3-cycle latency) for the softmax stage.
- Buffers one row of attention scores and tracks the row maximum.
- Issues max-subtracted operands to the exponent unit and collects its results into a credit-protected output FIFO.
- Accumulates the row denominator and hands exp values plus the sum downstream to the normaliser.

---
 rtl/softmax_exp_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/softmax_exp_scheduler.sv
// rtl/softmax_exp_scheduler.sv - row controller feeding the shared exponent unit for softmax
// Buffers a score row, issues max-subtracted operands, collects exp results into a credit FIFO.
module softmax_exp_scheduler #(
    parameter int MAX_LEN    = 64,
    parameter int EXP_LAT    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int SUM_W      = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [19:0]      in_data,
    input  logic             in_last,
    output logic [19:0]      exp_x,
    output logic             exp_issue,
    input  logic [24:0]      exp_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      out_data,
    output logic             out_last,
    output logic             sum_valid,
    output logic [SUM_W-1:0] sum_data,
    output logic             busy
);
    localparam int LW = $clog2(MAX_LEN);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXP, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [19:0]       r_buf [MAX_LEN];
    logic [19:0]       r_max;
    logic [LW:0]       r_count;
    logic [LW:0]       r_rd_idx;
    logic [CW-1:0]     r_credit;
    logic [EXP_LAT-1:0] r_trk_v;
    logic [EXP_LAT-1:0] r_trk_l;
    logic [SUM_W-1:0]  r_acc;
    logic [24:0]       r_fifo_d [FIFO_DEPTH];
    logic              r_fifo_l [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_fcnt;

    logic              w_in_hs;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_head_last;
    logic              w_sum_valid;
    logic [19:0]       w_rd_val;
    logic [20:0]       w_diff;
    logic [19:0]       w_sat;

    assign in_ready     = rst_n && (r_state == S_IDLE || r_state == S_LOAD);
    assign w_in_hs      = in_valid && in_ready;
    assign out_valid    = (r_fcnt != '0);
    assign w_pop        = out_valid && out_ready;
    assign w_head_last  = r_fifo_l[r_rd_ptr];
    assign out_data     = out_valid ? r_fifo_d[r_rd_ptr] : 25'd0;
    assign out_last     = out_valid && w_head_last;
    assign busy         = (r_state != S_IDLE);

    // Scores never exceed the row max, so the difference is <= 0 and only the negative side saturates.
    assign w_rd_val     = r_buf[r_rd_idx[LW-1:0]];
    assign w_diff       = {w_rd_val[19], w_rd_val} - {r_max[19], r_max};
    assign w_sat        = (w_diff[20:19] == 2'b10) ? 20'h80000 : w_diff[19:0];
    assign w_issue      = (r_state == S_EXP) && (r_credit != '0) && (r_rd_idx < r_count);
    assign w_issue_last = w_issue && (r_rd_idx == r_count - (LW+1)'(1));
    assign exp_issue    = w_issue;
    assign exp_x        = w_issue ? w_sat : 20'd0;

    assign w_push       = r_trk_v[EXP_LAT-1];
    assign w_sum_valid  = (r_state == S_DRAIN) && w_pop && w_head_last;
    assign sum_valid    = w_sum_valid;
    assign sum_data     = w_sum_valid ? r_acc : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_in_hs) w_next = in_last ? S_EXP : S_LOAD;
            S_LOAD:  if (w_in_hs && (in_last || r_count == (LW+1)'(MAX_LEN - 1))) w_next = S_EXP;
            S_EXP:   if (w_push && r_trk_l[EXP_LAT-1]) w_next = S_DRAIN;
            S_DRAIN: if (w_sum_valid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_max    <= '0;
            r_count  <= '0;
            r_rd_idx <= '0;
            r_credit <= CW'(FIFO_DEPTH);
            r_trk_v  <= '0;
            r_trk_l  <= '0;
            r_acc    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcnt   <= '0;
        end else begin
            r_state <= w_next;

            if (w_in_hs && r_state == S_IDLE) begin
                r_max    <= in_data;
                r_count  <= (LW+1)'(1);
                r_rd_idx <= '0;
            end else if (w_in_hs) begin
                if ($signed(in_data) > $signed(r_max)) r_max <= in_data;
                r_count <= r_count + (LW+1)'(1);
            end

            if (w_issue) r_rd_idx <= r_rd_idx + (LW+1)'(1);

            if (w_issue && !w_pop)      r_credit <= r_credit - CW'(1);
            else if (!w_issue && w_pop) r_credit <= r_credit + CW'(1);

            r_trk_v <= {r_trk_v[EXP_LAT-2:0], w_issue};
            r_trk_l <= {r_trk_l[EXP_LAT-2:0], w_issue_last};

            if (w_sum_valid)  r_acc <= '0;
            else if (w_push)  r_acc <= r_acc + {{(SUM_W-25){1'b0}}, exp_y};

            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_fcnt <= r_fcnt + CW'(1);
            else if (!w_push && w_pop) r_fcnt <= r_fcnt - CW'(1);
        end
    end

    // Storage arrays carry no reset; their contents are qualified by counts and pointers.
    always_ff @(posedge clk) begin
        if (w_in_hs) r_buf[(r_state == S_IDLE) ? '0 : r_count[LW-1:0]] <= in_data;
        if (w_push) begin
            r_fifo_d[r_wr_ptr] <= exp_y;
            r_fifo_l[r_wr_ptr] <= r_trk_l[EXP_LAT-1];
        end
    end
endmodule
